miner_ctrl: RTL

MINER_CTRL -- requirements
Module: miner_ctrl

---
 rtl/miner_ctrl_pkg.sv | 37 +++
 rtl/miner_frame_rx.sv | 77 +++++++
 rtl/miner_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/miner_ctrl_pkg.sv
// Shared definitions for the miner job controller: frame/result geometry,
// FSM state encoding and the result byte selector.
package miner_ctrl_pkg;

  localparam int FRAME_BYTES  = 44;
  localparam int RESULT_BYTES = 4;
  localparam int ARM_CYC      = 4;

  localparam int FRAME_W    = FRAME_BYTES * 8;
  localparam int MIDSTATE_W = 256;
  localparam int DATA2_W    = 96;
  localparam int BCNT_W     = $clog2(FRAME_BYTES);
  localparam int ARM_W      = $clog2(ARM_CYC);
  localparam int TXI_W      = $clog2(RESULT_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_ARM    = 3'd2,
    ST_MINING = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  // Nonce is sent most-significant byte first: index 0 is bits [31:24].
  function automatic logic [7:0] result_byte(input logic [31:0]      nonce,
                                             input logic [TXI_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = nonce[31:24];
      2'd1:    b = nonce[23:16];
      2'd2:    b = nonce[15:8];
      default: b = nonce[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/miner_frame_rx.sv
// Work frame assembler: shifts received bytes into a 352-bit register,
// counts bytes of the current frame, and drops a partial frame when the
// gap between bytes grows too long. Flags a completed frame as pending
// until the controller consumes it.
module miner_frame_rx
  import miner_ctrl_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYC = 32'd10_000_000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_valid_i,
  input  logic               clr_pending_i,
  output logic [FRAME_W-1:0] frame_o,
  output logic               frame_pending_o
);

  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [BCNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]        gap_q, gap_d;
  logic               pend_q, pend_d;
  logic               frame_done;

  // Next-state for shift register, byte counter, gap timer and pending flag.
  always_comb begin
    frame_d    = frame_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    frame_done = 1'b0;
    if (rx_valid_i) begin
      frame_d = {frame_q[FRAME_W-9:0], rx_data_i};
      gap_d   = '0;
      if (cnt_q == BCNT_W'(FRAME_BYTES - 1)) begin
        cnt_d      = '0;
        frame_done = 1'b1;
      end else begin
        cnt_d = cnt_q + BCNT_W'(1);
      end
    end else if (cnt_q != '0) begin
      // Counter back to zero discards the partial frame; the next 44 bytes
      // overwrite the whole shift register anyway.
      if (gap_q >= TIMEOUT_CYC - 32'd1) begin
        cnt_d = '0;
        gap_d = '0;
      end else begin
        gap_d = gap_q + 32'd1;
      end
    end
    // A frame completing on the clearing cycle must not be lost: set wins.
    pend_d = pend_q;
    if (clr_pending_i) pend_d = 1'b0;
    if (frame_done)    pend_d = 1'b1;
  end

  // Frame payload register; content is meaningful only once pending is set.
  always_ff @(posedge clk_i) begin
    frame_q <= frame_d;
  end

  // Control state of the assembler.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      gap_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gap_q  <= gap_d;
      pend_q <= pend_d;
    end
  end

  assign frame_o         = frame_q;
  assign frame_pending_o = pend_q;

endmodule

// File: rtl/miner_ctrl.sv
// Miner job controller: receives 44-byte work frames, launches the hashing
// core, and reports a found nonce as four bytes to the transmitter. A new
// frame arriving during mining aborts the running job and relaunches.
module miner_ctrl
  import miner_ctrl_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYC = 32'd10_000_000,
  parameter logic        NONCE_HALF  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [MIDSTATE_W-1:0] midstate,
  output logic [DATA2_W-1:0]    data2,
  output logic                  nonce_start,
  output logic                  start_mining,
  input  logic                  miner_busy,
  input  logic                  got_ticket,
  input  logic [31:0]           golden_nonce,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  job_active
);

  logic [1:0]            rst_sync_q;
  logic                  run;
  state_e                state_q, state_d;
  logic [ARM_W-1:0]      arm_q, arm_d;
  logic [TXI_W-1:0]      txi_q, txi_d;
  logic [31:0]           nonce_q, nonce_d;
  logic [MIDSTATE_W-1:0] mid_q;
  logic [DATA2_W-1:0]    d2_q;
  logic [FRAME_W-1:0]    frame;
  logic                  frame_pending;
  logic                  clr_pend;
  logic                  load_frame;

  miner_frame_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_frame_rx (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .clr_pending_i  (clr_pend),
    .frame_o        (frame),
    .frame_pending_o(frame_pending)
  );

  // Reset release is synchronised: the FSM runs two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run = rst_sync_q[1];

  // Job sequencing: next state, arm delay, nonce capture and tx byte index.
  always_comb begin
    state_d  = state_q;
    arm_d    = '0;
    txi_d    = txi_q;
    nonce_d  = nonce_q;
    clr_pend = 1'b0;
    case (state_q)
      ST_IDLE: begin
        txi_d = '0;
        if (frame_pending) state_d = ST_START;
      end
      ST_START: begin
        clr_pend = 1'b1;
        state_d  = ST_ARM;
      end
      // Busy and ticket are ignored here so a ticket still held from the
      // previous job is never mistaken for a result of this one.
      ST_ARM: begin
        if (arm_q == ARM_W'(ARM_CYC - 1)) state_d = ST_MINING;
        else                              arm_d   = arm_q + ARM_W'(1);
      end
      ST_MINING: begin
        if (frame_pending) begin
          state_d = ST_START;
        end else if (got_ticket) begin
          nonce_d = golden_nonce;
          txi_d   = '0;
          state_d = ST_REPORT;
        end else if (!miner_busy) begin
          state_d = ST_IDLE;
        end
      end
      ST_REPORT: begin
        if (tx_ready) begin
          if (txi_q == TXI_W'(RESULT_BYTES - 1)) begin
            txi_d   = '0;
            state_d = ST_IDLE;
          end else begin
            txi_d = txi_q + TXI_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!run) begin
      state_d  = ST_IDLE;
      clr_pend = 1'b0;
    end
  end

  // Work registers are captured on the edge entering START so they are
  // already valid while start_mining is high.
  assign load_frame = (state_d == ST_START);

  // FSM and job control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      arm_q   <= '0;
      txi_q   <= '0;
      nonce_q <= '0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      txi_q   <= txi_d;
      nonce_q <= nonce_d;
    end
  end

  // Work registers presented to the hashing core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mid_q <= '0;
      d2_q  <= '0;
    end else if (load_frame) begin
      mid_q <= frame[FRAME_W-1:DATA2_W];
      d2_q  <= frame[DATA2_W-1:0];
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    start_mining = (state_q == ST_START);
    job_active   = (state_q == ST_START) || (state_q == ST_ARM) ||
                   (state_q == ST_MINING);
    tx_valid     = (state_q == ST_REPORT);
    tx_data      = (state_q == ST_REPORT) ? result_byte(nonce_q, txi_q) : 8'h00;
  end

  assign nonce_start = NONCE_HALF;
  assign midstate    = mid_q;
  assign data2       = d2_q;

endmodule
